// File: rtl/regbank_sb_if.sv
// Bus bundle for regbank_sb: two read ports, one write port, and the claim port.
// The master drives addresses, write data and requests. The slave (the bank) returns data and status.
interface regbank_sb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [AW-1:0]    R1a;
    logic [WIDTH-1:0] R1d;
    logic             R1busy;
    logic [AW-1:0]    R2a;
    logic [WIDTH-1:0] R2d;
    logic             R2busy;
    logic [AW-1:0]    Wa;
    logic [WIDTH-1:0] Wd1;
    logic [WIDTH-1:0] Wd2;
    logic             WS;
    logic             Wen;
    logic [AW-1:0]    Ca;
    logic             Cen;
    logic             Cstall;
    logic [AW:0]      Nbusy;

    modport master (
        output R1a, R2a, Wa, Wd1, Wd2, WS, Wen, Ca, Cen,
        input  R1d, R1busy, R2d, R2busy, Cstall, Nbusy
    );

    modport slave (
        input  R1a, R2a, Wa, Wd1, Wd2, WS, Wen, Ca, Cen,
        output R1d, R1busy, R2d, R2busy, Cstall, Nbusy
    );
endinterface

// File: rtl/regbank_sb.sv
// Register bank with a per-register scoreboard: there are two bypassed read ports and one write port.
// A claim marks a register busy until a later write delivers its result.
module regbank_sb #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    regbank_sb_if.slave  bus
);
    localparam int NREGS = 2 ** AW;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [WIDTH-1:0] w_wd;
    logic             w_wr;
    logic             w_stall;
    logic             w_claim;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_nbusy;

    assign w_wd    = bus.WS ? bus.Wd2 : bus.Wd1;
    assign w_wr    = bus.Wen && (bus.Wa != '0);
    // A write that lands on the claimed register this cycle frees it, so the claim may proceed.
    assign w_stall = bus.Cen && (bus.Ca != '0) && r_busy[bus.Ca] &&
                     !(bus.Wen && (bus.Wa == bus.Ca));
    assign w_claim = bus.Cen && (bus.Ca != '0) && !w_stall;

    assign bus.R1d    = (w_wr && (bus.Wa == bus.R1a)) ? w_wd : r_regs[bus.R1a];
    assign bus.R2d    = (w_wr && (bus.Wa == bus.R2a)) ? w_wd : r_regs[bus.R2a];
    assign bus.R1busy = r_busy[bus.R1a] && !(bus.Wen && (bus.Wa == bus.R1a));
    assign bus.R2busy = r_busy[bus.R2a] && !(bus.Wen && (bus.Wa == bus.R2a));
    assign bus.Cstall = w_stall;
    assign bus.Nbusy  = w_nbusy;

    // The claim set is applied after the write clear, so a same-address write plus claim leaves the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr)
            w_busy_nxt[bus.Wa] = 1'b0;
        if (w_claim)
            w_busy_nxt[bus.Ca] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_nbusy = '0;
        for (int i = 1; i < NREGS; i++)
            w_nbusy = w_nbusy + {{AW{1'b0}}, r_busy[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr)
                r_regs[bus.Wa] <= w_wd;
            r_busy <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_regbank_sb.sv
// Bench for regbank_sb: a 16x8 bank checked against an array/scoreboard model under directed and random traffic.
// It also runs a directed pass on an 8-bit, 4-entry instance.
module tb_regbank_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    regbank_sb_if #(.WIDTH(16), .AW(3)) a ();
    regbank_sb_if #(.WIDTH(8),  .AW(2)) b ();

    regbank_sb #(.WIDTH(16), .AW(3)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
    regbank_sb #(.WIDTH(8),  .AW(2)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mreg [8];
    logic [7:0]  mbusy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv_a(input logic r, input logic [2:0] r1a, input logic [2:0] r2a,
                         input logic [2:0] wa, input logic [15:0] d1, input logic [15:0] d2,
                         input logic ws, input logic wen, input logic [2:0] ca, input logic cen);
        rst_a = r; a.R1a = r1a; a.R2a = r2a; a.Wa = wa; a.Wd1 = d1; a.Wd2 = d2;
        a.WS = ws; a.Wen = wen; a.Ca = ca; a.Cen = cen;
        #1;
    endtask

    // The task checks all outputs against the model before the edge, then advances the model across the edge.
    task automatic tick_a(output logic stalled);
        logic [15:0] wd;
        logic        st;
        @(negedge clk);
        wd = a.WS ? a.Wd2 : a.Wd1;
        st = a.Cen && a.Ca != 0 && mbusy[a.Ca] && !(a.Wen && a.Wa == a.Ca);
        chk("R1d", a.R1d, (a.Wen && a.Wa == a.R1a && a.R1a != 0) ? wd : mreg[a.R1a]);
        chk("R2d", a.R2d, (a.Wen && a.Wa == a.R2a && a.R2a != 0) ? wd : mreg[a.R2a]);
        chk("R1busy", a.R1busy, mbusy[a.R1a] && !(a.Wen && a.Wa == a.R1a));
        chk("R2busy", a.R2busy, mbusy[a.R2a] && !(a.Wen && a.Wa == a.R2a));
        chk("Cstall", a.Cstall, st);
        chk("Nbusy", a.Nbusy, $countones(mbusy));
        @(posedge clk);
        if (rst_a) begin
            for (int i = 0; i < 8; i++) mreg[i] = '0;
            mbusy = '0;
        end else begin
            if (a.Wen && a.Wa != 0) begin
                mreg[a.Wa] = wd;
                mbusy[a.Wa] = 1'b0;
            end
            if (a.Cen && a.Ca != 0 && !st) mbusy[a.Ca] = 1'b1;
        end
        stalled = st && !rst_a;
        #1;
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        s;
        logic        hold;
        logic [2:0]  hca;

        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mbusy = '0;
        drv_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- 8-bit, 4-entry instance ----
        rst_b = 1; b.R1a = 0; b.R2a = 0; b.Wa = 0; b.Wd1 = 0; b.Wd2 = 0;
        b.WS = 0; b.Wen = 0; b.Ca = 0; b.Cen = 0;
        step_b();
        rst_b = 0; #1;
        chk("B rst R1d", b.R1d, 0);
        chk("B rst Nbusy", b.Nbusy, 0);
        b.Wa = 3; b.Wd1 = 8'h34; b.WS = 0; b.Wen = 1; step_b();
        b.Wa = 1; b.Wd2 = 8'hEF; b.WS = 1; step_b();
        b.Wen = 0; b.R1a = 3; b.R2a = 1; #1;
        chk("B r3", b.R1d, 8'h34);
        chk("B r1", b.R2d, 8'hEF);
        b.Ca = 2; b.Cen = 1; step_b();
        b.R1a = 2; #1;
        chk("B claim Nbusy", b.Nbusy, 1);
        chk("B claim R1busy", b.R1busy, 1);
        chk("B reclaim Cstall", b.Cstall, 1);
        step_b();
        chk("B stall Nbusy", b.Nbusy, 1);
        b.Cen = 0; b.Wa = 2; b.Wd1 = 8'h42; b.WS = 0; b.Wen = 1; #1;
        chk("B wr R1busy", b.R1busy, 0);
        chk("B wr R1d", b.R1d, 8'h42);
        step_b();
        b.Wen = 0; #1;
        chk("B post Nbusy", b.Nbusy, 0);
        for (int i = 1; i < 4; i++) begin
            b.Ca = 2'(i); b.Cen = 1; step_b();
        end
        b.Cen = 0; #1;
        chk("B full Nbusy", b.Nbusy, 3);

        // ---- 16-bit, 8-entry instance: directed ----
        rst_b = 1;
        tick_a(s);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        chk("A rst R1d", a.R1d, 0);
        chk("A rst Cstall", a.Cstall, 0);
        chk("A rst Nbusy", a.Nbusy, 0);
        drv_a(0, 0, 0, 3, 16'h1234, 16'h0, 0, 1, 0, 0); tick_a(s);
        drv_a(0, 0, 0, 5, 16'h0, 16'hBEEF, 1, 1, 0, 0); tick_a(s);
        drv_a(0, 3, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("A r3", a.R1d, 16'h1234);
        chk("A r5", a.R2d, 16'hBEEF);
        tick_a(s);
        drv_a(0, 6, 0, 6, 16'hA5A5, 0, 0, 1, 0, 0);
        chk("A bypass", a.R1d, 16'hA5A5);
        tick_a(s);
        drv_a(0, 0, 0, 0, 16'hFFFF, 0, 0, 1, 0, 0); tick_a(s);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("A r0", a.R1d, 0);
        tick_a(s);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 2, 1); tick_a(s);
        drv_a(0, 2, 0, 0, 0, 0, 0, 0, 2, 1);
        chk("A claim Nbusy", a.Nbusy, 1);
        chk("A claim R1busy", a.R1busy, 1);
        chk("A reclaim Cstall", a.Cstall, 1);
        tick_a(s);
        drv_a(0, 2, 0, 2, 16'h0042, 0, 0, 1, 0, 0);
        chk("A wr R1busy", a.R1busy, 0);
        chk("A wr R1d", a.R1d, 16'h0042);
        tick_a(s);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("A post Nbusy", a.Nbusy, 0);
        tick_a(s);
        drv_a(0, 0, 0, 4, 16'h1111, 0, 0, 1, 4, 1); tick_a(s);
        drv_a(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("A wc r4 data", a.R1d, 16'h1111);
        chk("A wc r4 busy", a.R1busy, 1);
        tick_a(s);
        drv_a(0, 0, 0, 7, 16'h7777, 0, 0, 1, 1, 1); tick_a(s);
        drv_a(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("A split busy1", a.R1busy, 1);
        chk("A split r7", a.R2d, 16'h7777);
        tick_a(s);
        for (int i = 1; i < 8; i++) begin
            drv_a(0, 0, 0, 0, 0, 0, 0, 0, 3'(i), 1); tick_a(s);
        end
        drv_a(1, 1, 7, 1, 16'hDEAD, 0, 0, 1, 1, 1);
        chk("A all Nbusy", a.Nbusy, 7);
        tick_a(s);
        drv_a(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("A rst2 Nbusy", a.Nbusy, 0);
        chk("A rst2 R1d", a.R1d, 0);
        chk("A rst2 R2d", a.R2d, 0);
        tick_a(s);

        // ---- 16-bit instance: random traffic; a stalled claim is held until it is granted ----
        hold = 0; hca = 0;
        for (int n = 0; n < 400; n++) begin
            logic       cen;
            logic [2:0] ca;
            cen = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
            ca  = hold ? hca : 3'($urandom_range(0, 7));
            drv_a(($urandom_range(0, 60) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) != 0), ca, cen);
            tick_a(s);
            hold = s; hca = ca;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regbank_sb.md
REGBANK_SB -- requirements
Module: regbank_sb

Interface
REQ-001 Parameter WIDTH, default 16: register data width in bits, >= 1.
REQ-002 Parameter AW, default 3: address width; the bank holds NREGS = 2**AW registers, r0..r(NREGS-1), AW >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 R1a  input  AW  read port 1 address.
REQ-006 R1d  output  WIDTH  read port 1 data.
REQ-007 R1busy  output  1  read port 1 operand pending.
REQ-008 R2a  input  AW  read port 2 address.
REQ-009 R2d  output  WIDTH  read port 2 data.
REQ-010 R2busy  output  1  read port 2 operand pending.
REQ-011 Wa  input  AW  write address.
REQ-012 Wd1  input  WIDTH  write data source 0.
REQ-013 Wd2  input  WIDTH  write data source 1.
REQ-014 WS  input  1  write source select: 0 selects Wd1, 1 selects Wd2.
REQ-015 Wen  input  1  write enable.
REQ-016 Ca  input  AW  claim address, marking a register as awaiting a multi-cycle result.
REQ-017 Cen  input  1  claim request.
REQ-018 Cstall  output  1  claim refused this cycle.
REQ-019 Nbusy  output  AW+1  count of busy registers.

Function
REQ-020 Wd SHALL be Wd2 when WS=1 and Wd1 otherwise.
REQ-021 r0 SHALL always read 0; writes and claims addressed to 0 SHALL be ignored, and busy[0] SHALL stay 0.
REQ-022 On a rising edge with Wen=1, rst=0 and Wa!=0, r[Wa] SHALL take Wd; no other register SHALL change.
REQ-023 Reads SHALL be combinational: Rnd = r[Rna], except when Wen=1, Wa=Rna and Rna!=0, where Rnd SHALL equal the current-cycle Wd (write-through bypass, zero-cycle latency).
REQ-024 Each register i != 0 SHALL have a busy bit; an accepted claim SHALL set busy[Ca] on the edge, and a write SHALL clear busy[Wa] on the edge.
REQ-025 Write and accepted claim to the same address in one cycle: data SHALL be written and busy SHALL end at 1.
REQ-026 Write and claim to different addresses in one cycle: both effects SHALL apply independently.
REQ-027 Rnbusy SHALL be busy[Rna] AND NOT (Wen AND Wa=Rna); it SHALL be 0 when Rna=0.
REQ-028 Cstall SHALL be Cen AND Ca!=0 AND busy[Ca] AND NOT (Wen AND Wa=Ca).
REQ-029 A stalled claim SHALL leave all state unchanged; the requester SHALL hold Cen and Ca until Cstall=0.
REQ-030 Nbusy SHALL be the combinational population count of busy[NREGS-1:1], range 0..NREGS-1.
REQ-031 Writing a non-busy register SHALL be legal and SHALL leave its busy bit at 0.

Reset
REQ-032 With rst=1 on an edge, all registers and all busy bits SHALL become 0, overriding Wen and Cen in that cycle.
REQ-033 Outputs after reset SHALL be R1d=R2d=0, R1busy=R2busy=0, Nbusy=0, and Cstall=0 for any claim.
REQ-034 Reset asserted mid-claim or mid-write SHALL discard the pending operation with no partial update.

Verification
REQ-035 Reset, then write 16'h1234 to r3 via Wd1 (WS=0) and 16'hBEEF to r5 via Wd2 (WS=1) -> next cycle, R1a=3 gives 1234 and R2a=5 gives BEEF.
REQ-036 Wen=1, Wa=6, Wd=16'hA5A5, R1a=6 in the same cycle -> R1d=A5A5 before the edge; write to r0 with 16'hFFFF -> R1a=0 reads 0.
REQ-037 Claim r2 -> Nbusy=1, R1a=2 gives R1busy=1; a second claim of r2 -> Cstall=1 with Nbusy still 1; write r2=16'h0042 -> R1busy=0 in the write cycle, R1d=0042, and Nbusy=0 next cycle.
REQ-038 Claim r4 and write r4 in the same cycle -> r4 holds the written data and busy[4]=1; claim r1 and write r7 together -> busy[1]=1 and r7 updated.
REQ-039 Claim r1..r7 in seven cycles -> Nbusy=7; assert rst with Wen=1, Wa=1, Cen=1, Ca=1 -> all registers 0, Nbusy=0.
REQ-040 Instantiate with WIDTH=8, AW=2 and repeat REQ-035 and REQ-037 with truncated data -> identical behaviour, with Nbusy at most 3.
